// File: rtl/interrupt_controller_pkg.sv
// Shared encodings for the interrupt controller: FSM states, request kind,
// and the default handler vectors.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } ic_state_e;

  typedef enum logic {
    KIND_INT = 1'b0,
    KIND_NMI = 1'b1
  } ic_kind_e;

  localparam logic [31:0] DEF_NMI_VECTOR = 32'd20;
  localparam logic [31:0] DEF_INT_VECTOR = 32'd0;

endpackage

// File: rtl/interrupt_controller_priority_encoder_lsb.sv
// Combinational lowest-set-bit encoder; idx is 0 when nothing is set.
module priority_encoder_lsb #(
  parameter int W = 8
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched interrupt sources plus NMI, prioritised and presented to the
// CPU through a request / acknowledge / end-of-interrupt handshake.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC    = 8,
  parameter logic [31:0] NMI_VECTOR = DEF_NMI_VECTOR,
  parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [NUM_SRC-1:0] pend_clr,
  input  logic               cpu_busy,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               nmi_req,
  output logic               int_req,
  output logic [31:0]        int_vector,
  output logic [4:0]         int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               in_service
);

  logic [NUM_SRC-1:0] irq_q, irq_d, pending_q, pending_d, mask_q, mask_d;
  logic               nmi_q, nmi_d, nmi_pend_q, nmi_pend_d;
  ic_state_e          state_q, state_d;
  ic_kind_e           kind_q, kind_d;
  logic [31:0]        vector_q, vector_d;
  logic [4:0]         id_q, id_d;
  logic               nmi_req_q, nmi_req_d, int_req_q, int_req_d;
  logic               in_service_q, in_service_d;

  logic [NUM_SRC-1:0] irq_rise, eligible, ack_clr;
  logic               nmi_rise, win_valid, ack_int, ack_nmi;
  logic [4:0]         win_idx;

  assign irq_rise = irq_in & ~irq_q;
  assign nmi_rise = nmi_in & ~nmi_q;
  assign eligible = pending_q & ~mask_q;

  priority_encoder_lsb #(.W(NUM_SRC)) u_penc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    vector_d = vector_q;
    id_d     = id_q;
    ack_int  = 1'b0;
    ack_nmi  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nmi_pend_q && !cpu_busy) begin
          state_d  = ST_REQ;
          kind_d   = KIND_NMI;
          vector_d = NMI_VECTOR;
        end else if (win_valid && !cpu_busy) begin
          state_d  = ST_REQ;
          kind_d   = KIND_INT;
          vector_d = INT_VECTOR;
          id_d     = win_idx;
        end
      end
      ST_REQ: begin
        if (cpu_ack) begin
          state_d = ST_SERVICE;
          ack_nmi = (kind_q == KIND_NMI);
          ack_int = (kind_q == KIND_INT);
        end
      end
      ST_SERVICE: begin
        if (cpu_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests and in_service are decoded from the next state so they are
    // plain registered outputs.
    nmi_req_d    = (state_d == ST_REQ) && (kind_d == KIND_NMI);
    int_req_d    = (state_d == ST_REQ) && (kind_d == KIND_INT);
    in_service_d = (state_d == ST_SERVICE);
  end

  always_comb begin
    irq_d   = irq_in;
    nmi_d   = nmi_in;
    mask_d  = mask_we ? mask_wdata : mask_q;
    ack_clr = ack_int ? (NUM_SRC'(1) << id_q) : '0;
    // A fresh rise beats any clear arriving in the same cycle.
    pending_d  = (pending_q & ~(pend_clr | ack_clr)) | irq_rise;
    nmi_pend_d = (nmi_pend_q & ~ack_nmi) | nmi_rise;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      irq_q        <= '0;
      nmi_q        <= 1'b0;
      pending_q    <= '0;
      nmi_pend_q   <= 1'b0;
      mask_q       <= '1;
      state_q      <= ST_IDLE;
      kind_q       <= KIND_INT;
      vector_q     <= INT_VECTOR;
      id_q         <= '0;
      nmi_req_q    <= 1'b0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      irq_q        <= irq_d;
      nmi_q        <= nmi_d;
      pending_q    <= pending_d;
      nmi_pend_q   <= nmi_pend_d;
      mask_q       <= mask_d;
      state_q      <= state_d;
      kind_q       <= kind_d;
      vector_q     <= vector_d;
      id_q         <= id_d;
      nmi_req_q    <= nmi_req_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
    end
  end

  assign nmi_req    = nmi_req_q;
  assign int_req    = int_req_q;
  assign int_vector = vector_q;
  assign int_id     = id_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, mask_wdata, pend_clr;
  logic       nmi_in, mask_we, cpu_busy, cpu_ack, cpu_eoi;
  logic       nmi_req, int_req, in_service;
  logic [31:0] int_vector;
  logic [4:0] int_id;
  logic [7:0] pending, mask;

  int n_vec = 0;
  int n_err = 0;

  interrupt_controller #(.NUM_SRC(8)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .nmi_in     (nmi_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pend_clr   (pend_clr),
    .cpu_busy   (cpu_busy),
    .cpu_ack    (cpu_ack),
    .cpu_eoi    (cpu_eoi),
    .nmi_req    (nmi_req),
    .int_req    (int_req),
    .int_vector (int_vector),
    .int_id     (int_id),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; nmi_in = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    pend_clr = '0; cpu_busy = 1'b0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
    #12;
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_mask", 32'(mask), 32'hFF);
    chk("rst_vector", int_vector, 32'd0);
    chk("rst_reqs", {30'd0, nmi_req, int_req}, 32'd0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    // basic maskable flow on source 2
    mask_we = 1'b1; mask_wdata = 8'hFB; step();
    chk("t1_mask", 32'(mask), 32'hFB);
    mask_we = 1'b0; irq_in = 8'h04; step();
    chk("t1_pend", 32'(pending), 32'h04);
    chk("t1_noreq_yet", 32'(int_req), 32'd0);
    irq_in = '0; step();
    chk("t1_intreq", 32'(int_req), 32'd1);
    chk("t1_id", 32'(int_id), 32'd2);
    chk("t1_vec", int_vector, 32'd0);
    chk("t1_nmireq", 32'(nmi_req), 32'd0);
    cpu_ack = 1'b1; step();
    chk("t1_ack_pend", 32'(pending), 32'h00);
    chk("t1_insvc", 32'(in_service), 32'd1);
    chk("t1_req_drop", 32'(int_req), 32'd0);
    cpu_ack = 1'b0; cpu_eoi = 1'b1; step();
    chk("t1_eoi", 32'(in_service), 32'd0);
    cpu_eoi = 1'b0;

    // two sources together: lowest index first
    mask_we = 1'b1; mask_wdata = 8'h00; step();
    mask_we = 1'b0; irq_in = 8'h28; step();
    chk("t2_pend", 32'(pending), 32'h28);
    irq_in = '0; step();
    chk("t2_id_first", 32'(int_id), 32'd3);
    chk("t2_req_first", 32'(int_req), 32'd1);
    cpu_ack = 1'b1; step();
    chk("t2_pend_after_ack", 32'(pending), 32'h20);
    cpu_ack = 1'b0; cpu_eoi = 1'b1; step();
    cpu_eoi = 1'b0; step();
    chk("t2_req_second", 32'(int_req), 32'd1);
    chk("t2_id_second", 32'(int_id), 32'd5);
    cpu_ack = 1'b1; step();
    cpu_ack = 1'b0; cpu_eoi = 1'b1; step();
    cpu_eoi = 1'b0;
    chk("t2_pend_empty", 32'(pending), 32'h00);

    // NMI beats maskable
    nmi_in = 1'b1; irq_in = 8'h01; step();
    nmi_in = 1'b0; irq_in = '0; step();
    chk("t3_nmireq", 32'(nmi_req), 32'd1);
    chk("t3_intreq", 32'(int_req), 32'd0);
    chk("t3_vec", int_vector, 32'd20);
    cpu_ack = 1'b1; step();
    chk("t3_insvc", 32'(in_service), 32'd1);
    chk("t3_pend_kept", 32'(pending), 32'h01);
    cpu_ack = 1'b0; cpu_eoi = 1'b1; step();
    cpu_eoi = 1'b0; step();
    chk("t3_intreq_after", 32'(int_req), 32'd1);
    chk("t3_id_after", 32'(int_id), 32'd0);
    chk("t3_vec_after", int_vector, 32'd0);
    cpu_ack = 1'b1; step();
    cpu_ack = 1'b0; cpu_eoi = 1'b1; step();
    cpu_eoi = 1'b0;

    // busy holds off a request; busy in REQ does not drop it
    cpu_busy = 1'b1; irq_in = 8'h01; step();
    irq_in = '0;
    chk("t4_pend", 32'(pending), 32'h01);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_busy_noreq", 32'(int_req), 32'd0);
    end
    cpu_busy = 1'b0; step();
    chk("t4_req_unbusy", 32'(int_req), 32'd1);
    cpu_busy = 1'b1; step();
    chk("t4_req_hold1", 32'(int_req), 32'd1);
    step();
    chk("t4_req_hold2", 32'(int_req), 32'd1);
    cpu_ack = 1'b1; step();
    chk("t4_req_ack", 32'(int_req), 32'd0);
    chk("t4_insvc", 32'(in_service), 32'd1);
    cpu_ack = 1'b0; cpu_eoi = 1'b1; step();
    cpu_eoi = 1'b0;

    // set beats clear; masked pending raises nothing (busy keeps IDLE quiet)
    irq_in = 8'h02; pend_clr = 8'h02; step();
    chk("t5_set_wins", 32'(pending), 32'h02);
    irq_in = 8'h00; step();
    chk("t5_clear", 32'(pending), 32'h00);
    pend_clr = '0; mask_we = 1'b1; mask_wdata = 8'h02; step();
    mask_we = 1'b0; irq_in = 8'h02; step();
    irq_in = '0; cpu_busy = 1'b0;
    chk("t5_masked_pend", 32'(pending), 32'h02);
    step(); step();
    chk("t5_masked_noreq", 32'(int_req), 32'd0);
    chk("t5_masked_idle", 32'(in_service), 32'd0);

    // async reset while in service
    mask_we = 1'b1; mask_wdata = 8'h00; step();
    mask_we = 1'b0; step();
    chk("t6_req", 32'(int_req), 32'd1);
    chk("t6_id", 32'(int_id), 32'd1);
    cpu_ack = 1'b1; step();
    cpu_ack = 1'b0;
    chk("t6_insvc", 32'(in_service), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_insvc", 32'(in_service), 32'd0);
    chk("t6_rst_mask", 32'(mask), 32'hFF);
    chk("t6_rst_pend", 32'(pending), 32'h00);
    @(negedge clock);
    rst_n = 1'b1;
    step();
    chk("t6_quiet", {30'd0, nmi_req, int_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Source side of the CPU interrupt interface.
- Collects device interrupt lines and one external NMI line, then latches and prioritises them.
- Drives the CPU's non-maskable and maskable interrupt request inputs, gated by the CPU busy flag.
- Completes a request/acknowledge/end-of-interrupt handshake with the control unit, and supplies the handler vector and source id.

Parameters:
- NUM_SRC, 8, number of maskable interrupt sources (1..32).
- NMI_VECTOR, 32'd20, handler address reported for an NMI.
- INT_VECTOR, 32'd0, handler address reported for a maskable interrupt.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_SRC  device interrupt lines; rising-edge triggered.
- nmi_in  in  1  external NMI line; rising-edge triggered.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_SRC  new mask value; 1 = source masked.
- pend_clr  in  NUM_SRC  one-cycle clear strobes for pending bits.
- cpu_busy  in  1  CPU not ready to accept a new interrupt.
- cpu_ack  in  1  CPU has taken the request (asserted in its PC-save cycle).
- cpu_eoi  in  1  handler finished; return from interrupt.
- nmi_req  out  1  to CPU NMI input.
- int_req  out  1  to CPU maskable interrupt input.
- int_vector  out  32  handler address for the current request.
- int_id  out  5  source index of the current maskable request.
- pending  out  NUM_SRC  pending register.
- mask  out  NUM_SRC  mask register.
- in_service  out  1  a handler is active.

Behaviour:
- Reset values, applied asynchronously: pending=0, nmi_pend=0, mask=all ones, irq_q=0, nmi_q=0, state=IDLE, kind=INT, nmi_req=0, int_req=0, int_vector=INT_VECTOR, int_id=0, in_service=0.
- Edge detect: irq_q and nmi_q are registered copies of the inputs. A rise is `in & ~q`. A rise sets the pending bit (or nmi_pend) at that clock edge.
- Set/clear priority: a pending bit clears on pend_clr or on acknowledge of that source. A rise in the same cycle as a clear wins, so the bit stays 1. Levels held high do not retrigger.
- Mask: mask_we writes mask the same edge. Masking does not clear pending bits.
- eligible = pending & ~mask. The winner is the lowest eligible index.
- FSM states: IDLE, REQ, SERVICE.
- IDLE, NMI path: if nmi_pend and not cpu_busy, go to REQ with kind=NMI and int_vector=NMI_VECTOR.
- IDLE, maskable path: otherwise, if eligible is nonzero and not cpu_busy, go to REQ with kind=INT, int_vector=INT_VECTOR, and int_id = winner.
- IDLE, otherwise: stay in IDLE.
- REQ: nmi_req=1 when kind=NMI, int_req=1 when kind=INT; both are registered outputs, never both 1. The request holds regardless of cpu_busy or mask changes.
- REQ, on cpu_ack: clear nmi_pend or pending[int_id], then go to SERVICE.
- SERVICE: request outputs are 0 and in_service=1. On cpu_eoi, go to IDLE. New events keep latching, and a new NMI waits for eoi (no nesting). int_vector and int_id are stable from REQ entry to SERVICE exit.
- Latency: a rise sampled at edge k gives pending=1 after k. With cpu_busy=0, the request output is 1 after edge k+1.
- Ignored strobes: cpu_ack outside REQ and cpu_eoi outside SERVICE are ignored.
- Reset mid-operation: all state returns to reset values immediately, and requests drop asynchronously.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), the kind encoding, and the default vector constants.
- One natural sub-module, priority_encoder_lsb: NUM_SRC-wide, purely combinational; outputs a valid flag and a 5-bit index of the lowest set bit.

Test Plan:
- Reset, then mask_wdata=8'hFB with mask_we=1, then pulse irq_in[2] -> pending=8'h04 one edge later; int_req=1, int_id=2, int_vector=0 one edge after that. cpu_ack -> pending=0, in_service=1. cpu_eoi -> IDLE.
- Mask=0; irq_in[5] and irq_in[3] rise in the same cycle -> int_id=3. After ack and eoi -> second request with int_id=5.
- nmi_in and irq_in[0] rise together -> nmi_req=1, int_vector=20, int_req=0. After ack and eoi -> int_req=1 with int_id=0.
- cpu_busy=1 with pending=8'h01 -> no request for 10 cycles. Drop busy -> int_req=1 on the next edge. Raise busy during REQ -> int_req stays 1 until cpu_ack.
- Rise on irq_in[1] in the same cycle as pend_clr[1]=1 -> pending[1]=1. A pend_clr alone on the next cycle -> pending[1]=0. Masked source pending -> no request.
- rst_n low while in SERVICE -> in_service=0, mask=8'hFF, pending=0, with no clock edge needed.
